counter_arb: RTL and testbench
==============================

COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 4, max consecutive grants to one locked owner (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester request, held high until granted.
REQ-006 SHALL have port lock  input  NREQ  per-requester burst-lock request, qualified by req.
REQ-007 SHALL have port cnt  input  4  current value of the shared 4-bit counter (Counter4 cnt).
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, combinational from req/lock and registered state.
REQ-009 SHALL have port inc  output  1  increment strobe to the shared counter.
REQ-010 SHALL have port tag  output  4  counter value handed to the granted requester.
REQ-011 SHALL have port wrap  output  1  grant consumed value 4'hF (counter wraps to 0 next edge).

Function
REQ-012 SHALL keep registered state: fsm (IDLE, LOCKED), ptr (round-robin start index, 0..NREQ-1), owner (index), burst (4-bit count).
REQ-013 gnt SHALL have at most one bit set in every cycle; gnt[i] only when req[i]=1.
REQ-014 inc SHALL equal OR of gnt, same cycle; counter updates on that rising edge.
REQ-015 tag SHALL equal cnt in the grant cycle (pre-increment value); tag=0 when no grant.
REQ-016 wrap SHALL equal inc AND (cnt==4'hF).
REQ-017 IDLE: gnt SHALL select the first i with req[i]=1 searching ptr, ptr+1, ... modulo NREQ; none -> gnt=0.
REQ-018 IDLE, grant to i with lock[i]=0: ptr <= (i+1) mod NREQ, stay IDLE.
REQ-019 IDLE, grant to i with lock[i]=1 and MAX_BURST>1: fsm <= LOCKED, owner <= i, burst <= 1; ptr unchanged.
REQ-020 LOCKED with req[owner]=1 and lock[owner]=1: gnt SHALL be owner only; burst <= burst+1.
REQ-021 LOCKED grant making burst reach MAX_BURST: fsm <= IDLE, ptr <= (owner+1) mod NREQ after that grant.
REQ-022 LOCKED with req[owner]=0 or lock[owner]=0: no grant to owner that cycle; IDLE round-robin search from (owner+1) applied combinationally same cycle; fsm <= IDLE, ptr updated per REQ-018/019 as if IDLE.
REQ-023 Other requesters SHALL receive no grant while owner holds a valid lock.
REQ-024 Counter wrap-around SHALL NOT affect arbitration; tag follows cnt modulo 16.
REQ-025 Fairness: with all req high and lock low, each requester SHALL be granted exactly once per NREQ consecutive cycles.

Reset
REQ-026 While rst=1: gnt=0, inc=0, tag=0, wrap=0 regardless of req.
REQ-027 On rising edge with rst=1: fsm <= IDLE, ptr <= 0, owner <= 0, burst <= 0.
REQ-028 rst during LOCKED SHALL abandon the burst; first grant after rst release follows REQ-017 from ptr=0.

Verification
REQ-029 Reset: rst=1 2 cycles, req=4'b1111 -> gnt=0, inc=0; first cycle after release gnt=4'b0001, tag=cnt.
REQ-030 Round robin: req=4'b1111, lock=0, Counter4 at 0 -> gnt sequence 0001,0010,0100,1000,0001; tag 0,1,2,3,4; inc high every cycle.
REQ-031 Lock burst: MAX_BURST=4, req=4'b0011, lock=4'b0001 from ptr=0 -> gnt 0001 x4 then 0010; ptr=1 afterward.
REQ-032 Early unlock: owner 2 locked, lock[2] drops after 2 grants, req[3]=1 -> gnt=4'b1000 same cycle lock drops; fsm IDLE.
REQ-033 Wrap: single requester continuous, 17 grants -> tag 0..15,0; wrap=1 exactly on tag=15 grant.
REQ-034 Reset mid-lock: rst pulse during LOCKED owner 3, req=4'b1001 -> after release gnt=4'b0001 first.

Source files
------------

// File: rtl/counter_arb.sv
// counter_arb: round-robin arbiter with burst locking that hands out values
// of an external shared 4-bit counter. The granted requester receives the
// current counter value as its tag, and the counter is told to advance.
module counter_arb #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] lock,
   input  logic [3:0]      cnt,
   output logic [NREQ-1:0] gnt,
   output logic            inc,
   output logic [3:0]      tag,
   output logic            wrap
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e        fsm_q, fsm_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [3:0]    burst_q, burst_d;

   logic          hold;
   logic          found;
   logic [PW-1:0] base;
   logic [PW-1:0] sel;
   logic [PW-1:0] idx;

   // Successor index in the circular requester order.
   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] p);
      if (p == PW'(NREQ - 1)) return '0;
      else                    return p + PW'(1);
   endfunction

   // Owner keeps the grant while it still requests with lock; otherwise the
   // circular search starts at ptr (idle) or just past the owner (lock lost).
   always_comb begin
      hold  = (fsm_q == LOCKED) && req[owner_q] && lock[owner_q];
      base  = (fsm_q == LOCKED) ? next_idx(owner_q) : ptr_q;
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(base) + k) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Grant, counter strobe and tag; everything is silenced while in reset.
   always_comb begin
      gnt  = '0;
      inc  = 1'b0;
      tag  = 4'h0;
      wrap = 1'b0;
      if (!rst) begin
         if (hold)       gnt[owner_q] = 1'b1;
         else if (found) gnt[sel]     = 1'b1;
         inc  = |gnt;
         tag  = inc ? cnt : 4'h0;
         wrap = inc && (cnt == 4'hF);
      end
   end

   // Next-state: burst accounting while locked, round-robin advance otherwise.
   always_comb begin
      fsm_d   = fsm_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      burst_d = burst_q;
      if (hold) begin
         burst_d = burst_q + 4'd1;
         if (burst_q + 4'd1 == 4'(MAX_BURST)) begin
            fsm_d = IDLE;
            ptr_d = next_idx(owner_q);
         end
      end else begin
         // A lost lock behaves as idle arbitration starting past the owner.
         fsm_d = IDLE;
         ptr_d = base;
         if (found) begin
            if (lock[sel] && (MAX_BURST > 1)) begin
               fsm_d   = LOCKED;
               owner_d = sel;
               burst_d = 4'd1;
            end else begin
               ptr_d = next_idx(sel);
            end
         end
      end
   end

   // State registers with synchronous reset; reset abandons any burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         burst_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: tb/tb_counter_arb.sv
// Bench for counter_arb: drives directed and random request/lock patterns,
// plays the role of the shared 4-bit counter, and checks every cycle against
// a behavioural arbiter model plus literal expectations for key scenarios.
module tb_counter_arb;

   localparam int N  = 4;
   localparam int MB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'h0;
   logic [3:0] lock = 4'h0;
   logic [3:0] cnt;
   logic [3:0] gnt;
   logic [3:0] tag;
   logic       inc;
   logic       wrap;

   always #5 clk = ~clk;

   counter_arb #(.NREQ(N), .MAX_BURST(MB)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .lock (lock),
      .cnt  (cnt),
      .gnt  (gnt),
      .inc  (inc),
      .tag  (tag),
      .wrap (wrap)
   );

   // Model state: lock flag, round-robin pointer, owner, burst length, counter.
   bit         m_locked = 1'b0;
   int         m_ptr    = 0;
   int         m_owner  = 0;
   int         m_burst  = 0;
   logic [3:0] m_cnt    = 4'h0;

   assign cnt = m_cnt;

   int         e_g;
   logic [3:0] e_gnt;
   logic [3:0] e_tag;
   logic       e_inc;
   logic       e_wrap;
   bit         n_locked;
   int         n_ptr;
   int         n_owner;
   int         n_burst;
   int         start;

   int vecs = 0;
   int errs = 0;

   // Literal expectations posted by the stimulus process for the current cycle.
   bit         lit_on   = 1'b0;
   string      lit_name = "";
   logic [3:0] lit_gnt  = 4'h0;
   bit         lit_tc   = 1'b0;
   logic [3:0] lit_tag  = 4'h0;
   bit         lit_wc   = 1'b0;
   logic       lit_wrap = 1'b0;

   function automatic bit bitof(input logic [3:0] v, input int i);
      return v[i[1:0]];
   endfunction

   // Model: who should win this cycle, and what the arbiter remembers after.
   always_comb begin
      e_g      = -1;
      start    = m_ptr;
      n_locked = m_locked;
      n_ptr    = m_ptr;
      n_owner  = m_owner;
      n_burst  = m_burst;
      if (rst) begin
         n_locked = 1'b0;
         n_ptr    = 0;
         n_owner  = 0;
         n_burst  = 0;
      end else if (m_locked && bitof(req, m_owner) && bitof(lock, m_owner)) begin
         e_g     = m_owner;
         n_burst = m_burst + 1;
         if (n_burst == MB) begin
            n_locked = 1'b0;
            n_ptr    = (m_owner + 1) % N;
         end
      end else begin
         if (m_locked) begin
            start    = (m_owner + 1) % N;
            n_locked = 1'b0;
            n_ptr    = start;
         end
         for (int k = 0; k < N; k++)
            if (e_g < 0 && bitof(req, (start + k) % N)) e_g = (start + k) % N;
         if (e_g >= 0) begin
            if (bitof(lock, e_g) && MB > 1) begin
               n_locked = 1'b1;
               n_owner  = e_g;
               n_burst  = 1;
            end else begin
               n_ptr = (e_g + 1) % N;
            end
         end
      end
      e_gnt = 4'h0;
      if (e_g >= 0) e_gnt[e_g[1:0]] = 1'b1;
      e_inc  = (e_g >= 0);
      e_tag  = e_inc ? m_cnt : 4'h0;
      e_wrap = e_inc && (m_cnt == 4'hF);
   end

   // Model and shared counter advance on the clock edge.
   always @(posedge clk) begin
      m_locked <= n_locked;
      m_ptr    <= n_ptr;
      m_owner  <= n_owner;
      m_burst  <= n_burst;
      m_cnt    <= rst ? 4'h0 : m_cnt + {3'b000, e_inc};
   end

   // Compare process: sampled mid-cycle on the falling edge.
   always begin
      @(negedge clk);
      vecs++;
      if ({gnt, inc, tag, wrap} !== {e_gnt, e_inc, e_tag, e_wrap}) begin
         errs++;
         $display("FAIL model t=%0t: gnt=%b inc=%b tag=%h wrap=%b, expected gnt=%b inc=%b tag=%h wrap=%b",
                  $time, gnt, inc, tag, wrap, e_gnt, e_inc, e_tag, e_wrap);
      end
      if (lit_on) begin
         vecs++;
         if (gnt !== lit_gnt || inc !== (lit_gnt != 4'h0) ||
             (lit_tc && tag !== lit_tag) || (lit_wc && wrap !== lit_wrap)) begin
            errs++;
            $display("FAIL %s t=%0t: gnt=%b inc=%b tag=%h wrap=%b, expected gnt=%b tag=%h wrap=%b",
                     lit_name, $time, gnt, inc, tag, wrap, lit_gnt, lit_tag, lit_wrap);
         end
      end
   end

   task automatic drive(input logic rs, input logic [3:0] r, input logic [3:0] l);
      @(posedge clk);
      #1;
      rst    = rs;
      req    = r;
      lock   = l;
      lit_on = 1'b0;
   endtask

   task automatic expect_lit(input string nm, input logic [3:0] g,
                             input bit tc = 1'b0, input logic [3:0] t = 4'h0,
                             input bit wc = 1'b0, input logic w = 1'b0);
      lit_name = nm;
      lit_gnt  = g;
      lit_tc   = tc;
      lit_tag  = t;
      lit_wc   = wc;
      lit_wrap = w;
      lit_on   = 1'b1;
   endtask

   initial begin
      // Reset held with all requests high, then plain round robin.
      drive(1'b1, 4'hF, 4'h0); expect_lit("reset_a", 4'h0);
      drive(1'b1, 4'hF, 4'h0); expect_lit("reset_b", 4'h0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'hF, 4'h0);
         expect_lit("round_robin", 4'(1 << (i % 4)), 1'b1, 4'(i));
      end

      // Lock burst of MAX_BURST grants, then the next requester.
      drive(1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'b0011, 4'b0001);
         expect_lit("lock_burst", (i < 4) ? 4'b0001 : 4'b0010);
      end

      // Early unlock: owner 2 drops lock after two grants.
      drive(1'b1, 4'h0, 4'h0);
      drive(1'b0, 4'b0100, 4'b0100); expect_lit("unlock_g1", 4'b0100);
      drive(1'b0, 4'b0100, 4'b0100); expect_lit("unlock_g2", 4'b0100);
      drive(1'b0, 4'b1100, 4'b0000); expect_lit("unlock_drop", 4'b1000);
      drive(1'b0, 4'b0110, 4'b0000); expect_lit("unlock_idle", 4'b0010);

      // Counter wrap with a single continuous requester.
      drive(1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 17; i++) begin
         drive(1'b0, 4'b0001, 4'h0);
         expect_lit("wrap", 4'b0001, 1'b1, 4'(i % 16), 1'b1, (i == 15));
      end

      // Reset in the middle of a lock held by requester 3.
      drive(1'b1, 4'h0, 4'h0);
      drive(1'b0, 4'b1000, 4'b1000); expect_lit("midlock_g1", 4'b1000);
      drive(1'b0, 4'b1000, 4'b1000); expect_lit("midlock_g2", 4'b1000);
      drive(1'b1, 4'b1001, 4'b1001); expect_lit("midlock_rst", 4'h0);
      drive(1'b0, 4'b1001, 4'b0000); expect_lit("midlock_after", 4'b0001);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 31) == 0), 4'($urandom), 4'($urandom));

      drive(1'b0, 4'h0, 4'h0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
